// File: rtl/memory_load_align_pkg.sv
// Shared types for the load-align path: size and FSM state encodings.
// Build option MEMORY_LOAD_SPLIT_EN enables two-beat doubleword-crossing loads.
package memory_load_align_pkg;
  localparam int XLEN  = 64;
  localparam int OFF_W = 3;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_W0   = 3'd2,
`ifdef MEMORY_LOAD_SPLIT_EN
    S_RD1  = 3'd3,
    S_W1   = 3'd4,
`endif
    S_DONE = 3'd5
  } state_e;

  function automatic logic crosses(
    input logic [OFF_W-1:0] off,
    input size_e            sz
  );
    logic [3:0] end_b;
    end_b = {1'b0, off} + (4'd1 << sz);
    return end_b > 4'd8;
  endfunction
endpackage

// File: rtl/memory_load_align_if.sv
// Request, memory-read and result handshakes of the load-align block.
// slave = the aligner, master = LSU/memory/writeback side.
interface memory_load_align_if;
  import memory_load_align_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [OFF_W-1:0] req_offset;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic             mem_rd_valid;
  logic             mem_rd_ready;
  logic             mem_rd_hi;
  logic             mem_rdata_valid;
  logic [XLEN-1:0]  mem_rdata;
  logic             load_valid;
  logic             load_ready;
  logic [XLEN-1:0]  load_data;
  logic             load_err;

  modport slave (
    input  req_valid, req_offset, req_size, req_unsigned,
    input  mem_rd_ready, mem_rdata_valid, mem_rdata,
    input  load_ready,
    output req_ready, mem_rd_valid, mem_rd_hi,
    output load_valid, load_data, load_err
  );

  modport master (
    output req_valid, req_offset, req_size, req_unsigned,
    output mem_rd_ready, mem_rdata_valid, mem_rdata,
    output load_ready,
    input  req_ready, mem_rd_valid, mem_rd_hi,
    input  load_valid, load_data, load_err
  );
endinterface

// File: rtl/memory_load_extend.sv
// Right-aligns the addressed bytes of a 128b {hi,lo} window and
// sign/zero-extends them to 64 bits.
module memory_load_extend
  import memory_load_align_pkg::*;
(
  input  logic [2*XLEN-1:0] win_i,
  input  logic [OFF_W-1:0]  off_i,
  input  size_e             size_i,
  input  logic              uns_i,
  output logic [XLEN-1:0]   data_o
);
  logic [2*XLEN-1:0] sh;
  logic [XLEN-1:0]   s;
  logic              unused_hi;

  assign sh        = win_i >> {off_i, 3'b000};
  assign s         = sh[XLEN-1:0];
  assign unused_hi = ^sh[2*XLEN-1:XLEN];

  always_comb begin
    data_o = s;
    unique case (size_i)
      SIZE_B: data_o = {{56{~uns_i & s[7]}}, s[7:0]};
      SIZE_H: data_o = {{48{~uns_i & s[15]}}, s[15:0]};
      SIZE_W: data_o = {{32{~uns_i & s[31]}}, s[31:0]};
      SIZE_D: data_o = s;
    endcase
  end
endmodule

// File: rtl/memory_load_align.sv
// Load-path aligner: one load in flight, fetches 1-2 doublewords, aligns/extends.
// MEMORY_LOAD_SPLIT_EN: crossing loads use a second beat; otherwise they fault.
module memory_load_align
  import memory_load_align_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  memory_load_align_if.slave bus
);
  state_e           state_q, state_d;
  logic [OFF_W-1:0] off_q, off_d;
  size_e            size_q, size_d;
  logic             uns_q, uns_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             err_q, err_d;
  logic [2*XLEN-1:0] win;
  logic [XLEN-1:0]  ext_data;
  logic             req_cross;
`ifdef MEMORY_LOAD_SPLIT_EN
  logic             cross_q, cross_d;
  logic [XLEN-1:0]  lo_q, lo_d;
`endif

  assign req_cross = crosses(bus.req_offset, size_e'(bus.req_size));

`ifdef MEMORY_LOAD_SPLIT_EN
  assign win = (state_q == S_W1) ? {bus.mem_rdata, lo_q}
                                 : {{XLEN{1'b0}}, bus.mem_rdata};
`else
  assign win = {{XLEN{1'b0}}, bus.mem_rdata};
`endif

  memory_load_extend u_ext (
    .win_i  (win),
    .off_i  (off_q),
    .size_i (size_q),
    .uns_i  (uns_q),
    .data_o (ext_data)
  );

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef MEMORY_LOAD_SPLIT_EN
    cross_d = cross_q;
    lo_d    = lo_q;
`endif
    unique case (state_q)
      S_IDLE: if (bus.req_valid) begin
        off_d = bus.req_offset;
        size_d = size_e'(bus.req_size);
        uns_d = bus.req_unsigned;
        err_d = 1'b0;
`ifdef MEMORY_LOAD_SPLIT_EN
        cross_d = req_cross;
        state_d = S_RD0;
`else
        // crossing loads are refused without touching memory
        if (req_cross) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_RD0;
        end
`endif
      end
      S_RD0: if (bus.mem_rd_ready) state_d = S_W0;
      S_W0: if (bus.mem_rdata_valid) begin
`ifdef MEMORY_LOAD_SPLIT_EN
        lo_d = bus.mem_rdata;
        if (cross_q) begin
          state_d = S_RD1;
        end else begin
          data_d  = ext_data;
          state_d = S_DONE;
        end
`else
        data_d  = ext_data;
        state_d = S_DONE;
`endif
      end
`ifdef MEMORY_LOAD_SPLIT_EN
      S_RD1: if (bus.mem_rd_ready) state_d = S_W1;
      S_W1: if (bus.mem_rdata_valid) begin
        data_d  = ext_data;
        state_d = S_DONE;
      end
`endif
      S_DONE: if (bus.load_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      off_q   <= '0;
      size_q  <= SIZE_B;
      uns_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef MEMORY_LOAD_SPLIT_EN
      cross_q <= 1'b0;
      lo_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef MEMORY_LOAD_SPLIT_EN
      cross_q <= cross_d;
      lo_q    <= lo_d;
`endif
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.load_valid = (state_q == S_DONE);
  assign bus.load_data  = data_q;
  assign bus.load_err   = err_q;
`ifdef MEMORY_LOAD_SPLIT_EN
  assign bus.mem_rd_valid = (state_q == S_RD0) || (state_q == S_RD1);
  assign bus.mem_rd_hi    = (state_q == S_RD1);
`else
  assign bus.mem_rd_valid = (state_q == S_RD0);
  assign bus.mem_rd_hi    = 1'b0;
`endif
endmodule

// File: tb/tb_memory_load_align.sv
// Directed bench for memory_load_align; builds with or without
// MEMORY_LOAD_SPLIT_EN and expects the matching crossing behaviour.
module tb_memory_load_align;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  memory_load_align_if bus();
  memory_load_align dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [63:0] r_data;
  logic        r_err;
  int          r_beats;
  logic [1:0]  r_himask;
  int          r_lat;
  bit          r_stable, r_reacc, r_timeout, r_rdseen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays LSU, memory and consumer for one load; records what it saw.
  task automatic run_load(input logic [2:0] off, input logic [1:0] sz,
                          input logic un, input logic [63:0] lo,
                          input logic [63:0] hi, input int rd_stall,
                          input int ld_stall, input bit keep_req);
    int rs, ls, n;
    bit pend, pend_hi, rd_wait, ld_wait, done, prev_hi;
    r_data = '0; r_err = 1'b0; r_beats = 0; r_himask = 2'b00; r_lat = 0;
    r_stable = 1; r_reacc = 0; r_timeout = 0; r_rdseen = 0;
    rs = rd_stall; ls = ld_stall;
    pend = 0; pend_hi = 0; rd_wait = 0; ld_wait = 0; done = 0; prev_hi = 0;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.req_ready) begin
      r_timeout = 1;
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_offset = off;
    bus.req_size = sz;
    bus.req_unsigned = un;
    tick();
    if (!keep_req) bus.req_valid = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      bus.mem_rd_ready = 1'b0;
      bus.mem_rdata_valid = 1'b0;
      bus.load_ready = 1'b0;
      if (bus.req_ready) r_reacc = 1;
      if (pend) begin
        bus.mem_rdata_valid = 1'b1;
        bus.mem_rdata = pend_hi ? hi : lo;
        pend = 0;
      end else begin
        bus.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      if (rd_wait && (!bus.mem_rd_valid || bus.mem_rd_hi !== prev_hi))
        r_stable = 0;
      rd_wait = 0;
      if (bus.mem_rd_valid) begin
        r_rdseen = 1;
        prev_hi = bus.mem_rd_hi;
        if (rs > 0) begin
          rs--;
          rd_wait = 1;
        end else begin
          bus.mem_rd_ready = 1'b1;
          pend = 1;
          pend_hi = bus.mem_rd_hi;
          if (r_beats == 0) r_himask[0] = bus.mem_rd_hi;
          else if (r_beats == 1) r_himask[1] = bus.mem_rd_hi;
          r_beats++;
        end
      end
      if (ld_wait && (!bus.load_valid || bus.load_data !== r_data ||
                      bus.load_err !== r_err))
        r_stable = 0;
      ld_wait = 0;
      if (bus.load_valid) begin
        if (r_lat == 0) begin
          r_lat = c;
          r_data = bus.load_data;
          r_err = bus.load_err;
        end
        if (ls > 0) begin
          ls--;
          ld_wait = 1;
        end else begin
          bus.load_ready = 1'b1;
          done = 1;
        end
      end
      tick();
    end
    bus.req_valid = 1'b0;
    bus.mem_rd_ready = 1'b0;
    bus.mem_rdata_valid = 1'b0;
    bus.load_ready = 1'b0;
    if (!done) r_timeout = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready);
    end
    checks++;
    if ({bus.mem_rd_valid, bus.load_valid, bus.load_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_valids got=%b exp=000",
               {bus.mem_rd_valid, bus.load_valid, bus.load_err});
    end
    checks++;
    if (bus.load_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", bus.load_data);
    end
  endtask

  task automatic test_lw();
    run_load(3'd4, 2'd2, 1'b0, 64'h8765_4321_1122_3344, 64'h0, 0, 0, 0);
    checks++;
    if (r_timeout || r_data !== 64'hFFFF_FFFF_8765_4321 || r_err !== 1'b0) begin
      errors++;
      $display("FAIL lw_data got=%h err=%b to=%0d exp=ffffffff87654321 err=0",
               r_data, r_err, r_timeout);
    end
    checks++;
    if (r_beats !== 1 || r_himask[0] !== 1'b0) begin
      errors++;
      $display("FAIL lw_beats got=%0d hi=%b exp=1 hi=0", r_beats, r_himask[0]);
    end
    checks++;
    if (r_lat !== 3) begin
      errors++;
      $display("FAIL lw_latency got=%0d exp=3", r_lat);
    end
  endtask

  task automatic test_byte_off7();
    run_load(3'd7, 2'd0, 1'b1, 64'hAB00_0000_0000_0000, 64'h0, 0, 0, 0);
    checks++;
    if (r_timeout || r_data !== 64'h0000_0000_0000_00AB || r_err !== 1'b0 ||
        r_beats !== 1) begin
      errors++;
      $display("FAIL lbu_off7 got=%h err=%b beats=%0d exp=ab err=0 beats=1",
               r_data, r_err, r_beats);
    end
    run_load(3'd7, 2'd0, 1'b0, 64'hAB00_0000_0000_0000, 64'h0, 0, 0, 0);
    checks++;
    if (r_timeout || r_data !== 64'hFFFF_FFFF_FFFF_FFAB || r_err !== 1'b0) begin
      errors++;
      $display("FAIL lb_off7 got=%h err=%b exp=ffffffffffffffab err=0",
               r_data, r_err);
    end
  endtask

  task automatic test_ld_aligned();
    run_load(3'd0, 2'd3, 1'b0, 64'hF123_4567_89AB_CDEF, 64'h0, 0, 0, 0);
    checks++;
    if (r_timeout || r_data !== 64'hF123_4567_89AB_CDEF || r_err !== 1'b0 ||
        r_beats !== 1 || r_lat !== 3) begin
      errors++;
      $display("FAIL ld_off0 got=%h err=%b beats=%0d lat=%0d exp=f123456789abcdef 0 1 3",
               r_data, r_err, r_beats, r_lat);
    end
  endtask

  task automatic test_cross();
    run_load(3'd6, 2'd3, 1'b0, 64'h2211_0000_0000_0000,
             64'h0000_8877_6655_4433, 0, 0, 0);
`ifdef MEMORY_LOAD_SPLIT_EN
    checks++;
    if (r_timeout || r_data !== 64'h8877_6655_4433_2211 || r_err !== 1'b0) begin
      errors++;
      $display("FAIL ld_off6_data got=%h err=%b exp=8877665544332211 err=0",
               r_data, r_err);
    end
    checks++;
    if (r_beats !== 2 || r_himask !== 2'b10 || r_lat !== 5) begin
      errors++;
      $display("FAIL ld_off6_beats got=%0d hi=%b lat=%0d exp=2 hi=10 lat=5",
               r_beats, r_himask, r_lat);
    end
    run_load(3'd7, 2'd1, 1'b0, 64'h5A00_0000_0000_0000, 64'h0000_0000_0000_00F1,
             0, 0, 0);
    checks++;
    if (r_timeout || r_data !== 64'hFFFF_FFFF_FFFF_F15A || r_beats !== 2) begin
      errors++;
      $display("FAIL lh_off7 got=%h beats=%0d exp=fffffffffffff15a beats=2",
               r_data, r_beats);
    end
    run_load(3'd1, 2'd3, 1'b1, 64'hEEDD_CCBB_AA99_8877, 64'h0000_0000_0000_0066,
             0, 0, 0);
    checks++;
    if (r_timeout || r_data !== 64'h66EE_DDCC_BBAA_9988 || r_beats !== 2) begin
      errors++;
      $display("FAIL ld_off1 got=%h beats=%0d exp=66eeddccbbaa9988 beats=2",
               r_data, r_beats);
    end
`else
    checks++;
    if (r_timeout || r_data !== 64'h0 || r_err !== 1'b1) begin
      errors++;
      $display("FAIL ld_off6_fault got=%h err=%b exp=0 err=1", r_data, r_err);
    end
    checks++;
    if (r_rdseen || r_lat !== 1) begin
      errors++;
      $display("FAIL ld_off6_noread rd_seen=%0d lat=%0d exp=0 lat=1",
               r_rdseen, r_lat);
    end
    run_load(3'd7, 2'd1, 1'b0, 64'h5A00_0000_0000_0000, 64'h0000_0000_0000_00F1,
             0, 0, 0);
    checks++;
    if (r_timeout || r_err !== 1'b1 || r_data !== 64'h0 || r_rdseen) begin
      errors++;
      $display("FAIL lh_off7_fault got=%h err=%b rd=%0d exp=0 err=1 rd=0",
               r_data, r_err, r_rdseen);
    end
    run_load(3'd1, 2'd3, 1'b1, 64'hEEDD_CCBB_AA99_8877, 64'h0000_0000_0000_0066,
             0, 0, 0);
    checks++;
    if (r_timeout || r_err !== 1'b1 || r_data !== 64'h0 || r_rdseen) begin
      errors++;
      $display("FAIL ld_off1_fault got=%h err=%b rd=%0d exp=0 err=1 rd=0",
               r_data, r_err, r_rdseen);
    end
`endif
  endtask

  task automatic test_stall();
    run_load(3'd0, 2'd2, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0, 3, 4, 1);
    checks++;
    if (r_timeout || r_data !== 64'h0000_0000_9ABC_DEF0 || r_err !== 1'b0) begin
      errors++;
      $display("FAIL stall_data got=%h err=%b exp=9abcdef0 err=0", r_data, r_err);
    end
    checks++;
    if (!r_stable || r_reacc) begin
      errors++;
      $display("FAIL stall_hold stable=%0d reaccept=%0d exp=1 0", r_stable, r_reacc);
    end
    checks++;
    if (bus.load_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_idle load_valid=%b req_ready=%b exp=0 1",
               bus.load_valid, bus.req_ready);
    end
    tick();
    checks++;
    if (bus.mem_rd_valid !== 1'b0 || bus.load_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_reaccept rd_valid=%b load_valid=%b exp=0 0",
               bus.mem_rd_valid, bus.load_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 1'b1;
    bus.req_offset = 3'd2;
    bus.req_size = 2'd1;
    bus.req_unsigned = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    bus.mem_rd_ready = 1'b1;
    tick();
    bus.mem_rd_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.mem_rdata_valid = 1'b0;
    checks++;
    if (bus.load_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
        bus.mem_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle lv=%b rr=%b rv=%b exp=0 1 0",
               bus.load_valid, bus.req_ready, bus.mem_rd_valid);
    end
    tick();
    checks++;
    if (bus.load_valid !== 1'b0 || bus.load_data !== 64'h0) begin
      errors++;
      $display("FAIL midreset_stray lv=%b data=%h exp=0 0",
               bus.load_valid, bus.load_data);
    end
    run_load(3'd2, 2'd1, 1'b0, 64'h1111_2222_BEEF_3333, 64'h0, 0, 0, 0);
    checks++;
    if (r_timeout || r_data !== 64'hFFFF_FFFF_FFFF_BEEF || r_lat !== 3) begin
      errors++;
      $display("FAIL midreset_lh got=%h lat=%0d exp=ffffffffffffbeef lat=3",
               r_data, r_lat);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_offset = 3'd0;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.mem_rd_ready = 1'b0;
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata = 64'h0;
    bus.load_ready = 1'b0;
    test_reset();
    test_lw();
    test_byte_off7();
    test_ld_aligned();
    test_cross();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
